seg_scan_ctrl: RTL and testbench

Multiplexed 7-segment display scan controller. It shares one segment bus among NUM_DIG digits, advancing one digit per 1 kHz scan tick from the clock pulse generator, with a dead-time blank between digits to prevent ghosting. Host writes are double-buffered and become visible only at a frame boundary, so the display never tears. Sits between key/counter logic and the board's segment/common pins.

---
 rtl/seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one digit per scan tick, dead-time blank
// between digits, double-buffered host data that swaps in only at a frame boundary.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | after reset, everything off, waiting for the first tick
// ST_BLANK | dead time after a tick, commons off, down-counter running
// ST_SHOW  | common of the current digit driven until the next tick
`timescale 1ns/1ps
module seg_scan_ctrl #(
  parameter int NUM_DIG     = 4,
  parameter int BLANK_CYC   = 16,
  parameter int SEG_ACT_LOW = 1,
  parameter int COM_ACT_LOW = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_tick,
  input  logic                 i_wr,
  input  logic [4*NUM_DIG-1:0] i_data,
  input  logic [NUM_DIG-1:0]   i_dp,
  input  logic                 i_lzs,
  output logic [6:0]           o_seg,
  output logic                 o_dp,
  output logic [NUM_DIG-1:0]   o_com,
  output logic                 o_frame,
  output logic                 o_upd
);

  localparam int IDX_W = $clog2(NUM_DIG);
  localparam int CNT_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_DIG - 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(BLANK_CYC - 1);
  localparam logic [6:0]         SEG_OFF  = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic               DP_OFF   = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] COM_OFF  = (COM_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : {NUM_DIG{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic [4*NUM_DIG-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIG-1:0]   pend_dp_q, pend_dp_d;
  logic                 pend_lzs_q, pend_lzs_d;
  logic                 pend_q, pend_d;

  logic [4*NUM_DIG-1:0] act_data_q, act_data_d;
  logic [NUM_DIG-1:0]   act_dp_q, act_dp_d;
  logic                 act_lzs_q, act_lzs_d;

  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [NUM_DIG-1:0]   com_q, com_d;
  logic                 frame_q, frame_d;
  logic                 upd_q, upd_d;

  logic                 boundary;
  logic [NUM_DIG-1:0]   lz_blank;
  logic [3:0]           nib;
  logic [6:0]           seg_raw;
  logic [NUM_DIG-1:0]   com_raw;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Sequencing, scan index and buffer handling.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_lzs_d  = pend_lzs_q;
    pend_d      = pend_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_lzs_d   = act_lzs_q;
    frame_d     = 1'b0;
    upd_d       = 1'b0;
    boundary    = i_tick && (idx_q == IDX_LAST);

    // A tick in any state restarts the dead time, so a too-long blank cannot lock up.
    if (i_tick) begin
      idx_d   = boundary ? '0 : idx_q + 1'b1;
      state_d = ST_BLANK;
      cnt_d   = CNT_LOAD;
    end else if (state_q == ST_BLANK) begin
      if (cnt_q == '0) begin
        state_d = ST_SHOW;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (boundary) begin
      frame_d = 1'b1;
      if (pend_q) begin
        act_data_d = pend_data_q;
        act_dp_d   = pend_dp_q;
        act_lzs_d  = pend_lzs_q;
        pend_d     = 1'b0;
        upd_d      = 1'b1;
      end
    end

    // Evaluated after the copy so a write on a boundary lands in the next frame.
    if (i_wr) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      pend_lzs_d  = i_lzs;
      pend_d      = 1'b1;
    end
  end

  assign lz_blank[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIG; k++) begin : g_lz
    assign lz_blank[k] = act_lzs_d && (act_data_d[4*NUM_DIG-1:4*k] == '0);
  end

  // Output decode uses next-cycle values so everything lines up at T+1.
  always_comb begin
    nib     = act_data_d[4*idx_d +: 4];
    seg_raw = lz_blank[idx_d] ? 7'h00 : hex7(nib);
    com_raw = '0;
    com_raw[idx_d] = 1'b1;

    if (state_d == ST_IDLE) begin
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
    end else begin
      seg_d = (SEG_ACT_LOW != 0) ? ~seg_raw : seg_raw;
      dp_d  = (SEG_ACT_LOW != 0) ? ~act_dp_d[idx_d] : act_dp_d[idx_d];
    end

    if (state_d == ST_SHOW) begin
      com_d = (COM_ACT_LOW != 0) ? ~com_raw : com_raw;
    end else begin
      com_d = COM_OFF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= IDX_LAST;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_lzs_q  <= 1'b0;
      pend_q      <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_lzs_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      dp_q        <= DP_OFF;
      com_q       <= COM_OFF;
      frame_q     <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_lzs_q  <= pend_lzs_d;
      pend_q      <= pend_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_lzs_q   <= act_lzs_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      com_q       <= com_d;
      frame_q     <= frame_d;
      upd_q       <= upd_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_com   = com_q;
  assign o_frame = frame_q;
  assign o_upd   = upd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with default parameters (4 digits, 16-cycle blank,
// active-low segments and commons); expected values are hand-decoded constants.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rstn;
  logic        tick;
  logic        wr;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        lzs;
  logic [6:0]  seg;
  logic        odp;
  logic [3:0]  com;
  logic        frame;
  logic        upd;

  int n_chk = 0;
  int n_bad = 0;

  seg_scan_ctrl dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_tick  (tick),
    .i_wr    (wr),
    .i_data  (data),
    .i_dp    (dp),
    .i_lzs   (lzs),
    .o_seg   (seg),
    .o_dp    (odp),
    .o_com   (com),
    .o_frame (frame),
    .o_upd   (upd)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] d, input logic [3:0] p, input logic z);
    wr = 1'b1; data = d; dp = p; lzs = z;
    step(1);
    wr = 1'b0;
  endtask

  // Tick, check the digit shown right away, then check its common after the blank.
  task automatic tick_show(input string tag, input logic [6:0] exp_seg, input logic [3:0] exp_com);
    do_tick();
    chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    chk({tag, "_com_blank"}, 32'(com), 32'hF);
    step(16);
    chk({tag, "_com"}, 32'(com), 32'(exp_com));
  endtask

  initial begin
    rstn = 1'b0; tick = 1'b0; wr = 1'b0; data = '0; dp = '0; lzs = 1'b0;
    step(3);
    chk("rst_hold", {seg, odp, com, frame, upd}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    rstn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("rst_idle", {seg, odp, com, frame, upd}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    end

    // First frame with 1234
    do_write(16'h1234, 4'h0, 1'b0);
    do_tick();
    chk("t1_upd", 32'(upd), 32'h1);
    chk("t1_frame", 32'(frame), 32'h1);
    chk("t1_seg", 32'(seg), 32'h19);
    chk("t1_dp", 32'(odp), 32'h1);
    chk("t1_com0", 32'(com), 32'hF);
    step(1);
    chk("t1_frame_1cyc", 32'(frame), 32'h0);
    chk("t1_upd_1cyc", 32'(upd), 32'h0);
    step(14);
    chk("t1_com_t16", 32'(com), 32'hF);
    step(1);
    chk("t1_com_t17", 32'(com), 32'hE);
    tick_show("d1", 7'h30, 4'hD);
    chk("d1_frame", 32'(frame), 32'h0);
    tick_show("d2", 7'h24, 4'hB);
    tick_show("d3", 7'h79, 4'h7);

    // Mid-frame write of AAAA while idx=1
    do_tick();
    chk("mf_b0_frame", 32'(frame), 32'h1);
    chk("mf_b0_upd", 32'(upd), 32'h0);
    chk("mf_b0_seg", 32'(seg), 32'h19);
    step(16);
    do_tick();
    chk("mf_i1_seg", 32'(seg), 32'h30);
    do_write(16'hAAAA, 4'b0100, 1'b0);
    step(15);
    tick_show("mf_i2", 7'h24, 4'hB);
    chk("mf_i2_dp_old", 32'(odp), 32'h1);
    tick_show("mf_i3", 7'h79, 4'h7);
    do_tick();
    chk("mf_b1_upd", 32'(upd), 32'h1);
    chk("mf_b1_seg", 32'(seg), 32'h08);
    step(16);
    tick_show("mf_n1", 7'h08, 4'hD);
    tick_show("mf_n2", 7'h08, 4'hB);
    chk("mf_n2_dp", 32'(odp), 32'h0);
    tick_show("mf_n3", 7'h08, 4'h7);
    do_tick();
    chk("mf_b2_upd_once", 32'(upd), 32'h0);
    chk("mf_b2_seg", 32'(seg), 32'h08);
    step(16);

    // Leading-zero suppression: 0050
    do_write(16'h0050, 4'h0, 1'b1);
    tick_show("lz_w1", 7'h08, 4'hD);
    tick_show("lz_w2", 7'h08, 4'hB);
    tick_show("lz_w3", 7'h08, 4'h7);
    do_tick();
    chk("lz_upd", 32'(upd), 32'h1);
    chk("lz_d0", 32'(seg), 32'h40);
    step(16);
    tick_show("lz_d1", 7'h12, 4'hD);
    tick_show("lz_d2", 7'h7F, 4'hB);
    tick_show("lz_d3", 7'h7F, 4'h7);
    do_write(16'h0050, 4'h0, 1'b0);
    tick_show("nz_d0", 7'h40, 4'hE);
    chk("nz_upd", 32'(upd), 32'h0);
    tick_show("nz_d1", 7'h12, 4'hD);
    tick_show("nz_d2", 7'h40, 4'hB);
    tick_show("nz_d3", 7'h40, 4'h7);

    // Write on the same cycle as the boundary tick
    do_write(16'h1111, 4'h0, 1'b0);
    wr = 1'b1; data = 16'h2222;
    do_tick();
    wr = 1'b0;
    chk("sw_b0_upd", 32'(upd), 32'h1);
    chk("sw_b0_seg", 32'(seg), 32'h79);
    step(16);
    tick_show("sw_d1", 7'h79, 4'hD);
    tick_show("sw_d2", 7'h79, 4'hB);
    tick_show("sw_d3", 7'h79, 4'h7);
    do_tick();
    chk("sw_b1_upd", 32'(upd), 32'h1);
    chk("sw_b1_seg", 32'(seg), 32'h24);
    step(16);

    // Tick during the blank restarts the dead time
    do_tick();
    step(5);
    do_tick();
    chk("rb_seg", 32'(seg), 32'h24);
    step(15);
    chk("rb_com_t16", 32'(com), 32'hF);
    step(1);
    chk("rb_com_t17", 32'(com), 32'hB);

    // Async reset while showing idx=2
    rstn = 1'b0;
    #1;
    chk("ar_now", {seg, odp, com, frame, upd}, {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0});
    step(3);
    rstn = 1'b1;
    step(5);
    chk("ar_idle", {seg, odp, com}, {7'h7F, 1'b1, 4'hF});
    do_tick();
    chk("ar_t1_seg", 32'(seg), 32'h40);
    chk("ar_t1_frame", 32'(frame), 32'h1);
    chk("ar_t1_upd", 32'(upd), 32'h0);
    step(16);
    chk("ar_t1_com", 32'(com), 32'hE);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
